// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the single-clock FIFO controller.
// Pointers carry one extra wrap bit above the RAM address width.
package fifo_pkg;

    localparam int unsigned ADDR_W_DEF    = 8;
    localparam int unsigned DEPTH_DEF     = 32'd1 << ADDR_W_DEF;
    localparam int unsigned AF_THRESH_DEF = 240;
    localparam int unsigned AE_THRESH_DEF = 16;

    typedef logic [ADDR_W_DEF:0] ptr_t;
    typedef logic [ADDR_W_DEF:0] cnt_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer register: advances by one on inc and wraps modulo 2**PTR_W.
// The top bit toggles every time the RAM address wraps.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int unsigned PTR_W = $bits(ptr_t)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_r;

    // Pointer register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= {PTR_W{1'b0}};
        end else if (inc) begin
            ptr_r <= ptr_r + PTR_W'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller for a dual-port RAM: pointer sequencing, RAM enables,
// registered occupancy/flags and sticky overflow/underflow errors.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned AF_THRESH = AF_THRESH_DEF,
    parameter int unsigned AE_THRESH = AE_THRESH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic              err_clr,
    output logic              ram_w_en,
    output logic [ADDR_W-1:0] ram_w_ptr,
    output logic              ram_r_en,
    output logic [ADDR_W-1:0] ram_r_ptr,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 32'd1 << ADDR_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    logic             wr_acc_s;
    logic             rd_acc_s;
    logic [CNT_W-1:0] wptr_s;
    logic [CNT_W-1:0] rptr_s;
    logic [CNT_W-1:0] count_nxt_s;

    logic [CNT_W-1:0] count_r;
    logic             full_r;
    logic             empty_r;
    logic             almost_full_r;
    logic             almost_empty_r;
    logic             rd_valid_r;
    logic             overflow_r;
    logic             underflow_r;

    // Acceptance uses last edge's flags only; no full/empty bypass
    assign wr_acc_s = wr_req && !full_r;
    assign rd_acc_s = rd_req && !empty_r;

    fifo_ptr #(.PTR_W(CNT_W)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wr_acc_s),
        .ptr   (wptr_s)
    );

    fifo_ptr #(.PTR_W(CNT_W)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rd_acc_s),
        .ptr   (rptr_s)
    );

    // Next occupancy from the accepted write/read pair
    always_comb begin
        count_nxt_s = count_r;
        if (wr_acc_s && !rd_acc_s) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else if (rd_acc_s && !wr_acc_s) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Occupancy, flags, read-valid and sticky error registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r        <= {CNT_W{1'b0}};
            full_r         <= 1'b0;
            empty_r        <= 1'b1;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
            rd_valid_r     <= 1'b0;
            overflow_r     <= 1'b0;
            underflow_r    <= 1'b0;
        end else begin
            count_r        <= count_nxt_s;
            full_r         <= (count_nxt_s == DEPTH_C);
            empty_r        <= (count_nxt_s == {CNT_W{1'b0}});
            almost_full_r  <= (count_nxt_s >= AF_C);
            almost_empty_r <= (count_nxt_s <= AE_C);
            rd_valid_r     <= rd_acc_s;
            // A new error event takes priority over a clear in the same cycle
            overflow_r     <= (wr_req && full_r)  || (overflow_r  && !err_clr);
            underflow_r    <= (rd_req && empty_r) || (underflow_r && !err_clr);
        end
    end

    assign ram_w_en     = wr_acc_s;
    assign ram_r_en     = rd_acc_s;
    assign ram_w_ptr    = wptr_s[ADDR_W-1:0];
    assign ram_r_ptr    = rptr_s[ADDR_W-1:0];
    assign rd_valid     = rd_valid_r;
    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = almost_full_r;
    assign almost_empty = almost_empty_r;
    assign count        = count_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: behavioural RAM plus a queue-based FIFO model,
// scenario tasks with inline comparisons and a randomized phase.
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_req = 1'b0;
    logic       rd_req = 1'b0;
    logic       err_clr = 1'b0;
    logic       ram_w_en, ram_r_en, rd_valid;
    logic [7:0] ram_w_ptr, ram_r_ptr;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [8:0] count;

    logic [7:0] wdata = 8'd0;
    logic [7:0] mem [256];
    logic [7:0] ram_dout;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] q[$];
    int         m_wn, m_rn;
    logic       m_ovf, m_unf, m_rdv;
    logic [7:0] m_data;
    // Pre-edge samples and their expected values
    logic       s_wen, s_ren, e_wen, e_ren;
    logic [7:0] s_wp, s_rp, e_wp, e_rp;

    fifo_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .err_clr      (err_clr),
        .ram_w_en     (ram_w_en),
        .ram_w_ptr    (ram_w_ptr),
        .ram_r_en     (ram_r_en),
        .ram_r_ptr    (ram_r_ptr),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Behavioural 256x8 RAM with registered data_out
    always @(posedge clk) begin
        if (ram_w_en) mem[ram_w_ptr] <= wdata;
        if (ram_r_en) ram_dout <= mem[ram_r_ptr];
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] exp_vec();
        int n;
        n = q.size();
        return {9'(n), n == 256, n == 0, n >= 240, n <= 16, m_ovf, m_unf, m_rdv};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {count, full, empty, almost_full, almost_empty, overflow, underflow, rd_valid};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; err_clr = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        m_wn = 0; m_rn = 0; m_ovf = 1'b0; m_unf = 1'b0; m_rdv = 1'b0; m_data = 8'd0;
    endtask

    task automatic cycle(input logic w, input logic r, input logic c, input logic [7:0] d);
        logic f, e, wa, ra;
        @(negedge clk);
        wr_req = w; rd_req = r; err_clr = c; wdata = d;
        #1;
        s_wen = ram_w_en; s_ren = ram_r_en; s_wp = ram_w_ptr; s_rp = ram_r_ptr;
        f  = (q.size() == 256);
        e  = (q.size() == 0);
        wa = w && !f;
        ra = r && !e;
        e_wen = wa; e_ren = ra; e_wp = m_wn[7:0]; e_rp = m_rn[7:0];
        @(posedge clk); #1;
        m_ovf = (w && f) || (m_ovf && !c);
        m_unf = (r && e) || (m_unf && !c);
        m_rdv = ra;
        if (ra) begin
            m_data = q.pop_front();
            m_rn++;
        end
        if (wa) begin
            q.push_back(d);
            m_wn++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (dut_vec() !== 16'b000000000_0101000) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", dut_vec(), 16'b000000000_0101000);
        end
        checks++;
        if ({s_wen, s_ren} !== 2'b00) begin
            errors++;
            $display("FAIL reset_enables: got %b want 00", {s_wen, s_ren});
        end
    endtask

    task automatic test_write_read();
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 8'(i));
            checks++;
            if ({s_wen, s_wp} !== {1'b1, 8'(i - 1)}) begin
                errors++;
                $display("FAIL wr_ptr%0d: got %b/%0d want 1/%0d", i, s_wen, s_wp, i - 1);
            end
        end
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'd0);
            checks++;
            if ({s_ren, s_rp, rd_valid, ram_dout} !== {1'b1, 8'(i - 1), 1'b1, 8'(i)}) begin
                errors++;
                $display("FAIL rd_data%0d: got en=%b ptr=%0d v=%b d=%0d want 1/%0d/1/%0d",
                         i, s_ren, s_rp, rd_valid, ram_dout, i - 1, i);
            end
        end
        checks++;
        if ({count, empty} !== {9'd0, 1'b1}) begin
            errors++;
            $display("FAIL wr_rd_final: got count=%0d empty=%b want 0/1", count, empty);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 1; i <= 256; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL fill_%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if ({full, almost_full, count} !== {1'b1, 1'b1, 9'd256}) begin
            errors++;
            $display("FAIL fill_full: got f=%b af=%b c=%0d want 1/1/256", full, almost_full, count);
        end
        cycle(1'b1, 1'b0, 1'b0, 8'hEE);
        checks++;
        if ({s_wen, s_wp, count, overflow} !== {1'b0, 8'd0, 9'd256, 1'b1}) begin
            errors++;
            $display("FAIL fill_257: got en=%b wp=%0d c=%0d ovf=%b want 0/0/256/1",
                     s_wen, s_wp, count, overflow);
        end
    endtask

    task automatic test_full_rdwr();
        cycle(1'b1, 1'b1, 1'b0, 8'h55);
        checks++;
        if ({s_wen, s_ren, count, full, overflow} !== {1'b0, 1'b1, 9'd255, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL full_rdwr: got we=%b re=%b c=%0d f=%b ovf=%b want 0/1/255/0/1",
                     s_wen, s_ren, count, full, overflow);
        end
        checks++;
        if ({rd_valid, ram_dout} !== {1'b1, m_data}) begin
            errors++;
            $display("FAIL full_rdwr_data: got %b/%h want 1/%h", rd_valid, ram_dout, m_data);
        end
        cycle(1'b0, 1'b0, 1'b1, 8'd0);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: got ovf=%b want 0", overflow);
        end
    endtask

    task automatic test_soak();
        while (q.size() > 100) cycle(1'b0, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 600; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 8'($urandom));
            checks++;
            if ({count, empty, full, rd_valid, ram_dout, s_wp, s_rp} !==
                {9'd100, 1'b0, 1'b0, 1'b1, m_data, e_wp, e_rp}) begin
                errors++;
                $display("FAIL soak_%0d: got c=%0d e=%b f=%b v=%b d=%h wp=%0d rp=%0d want 100/0/0/1/%h/%0d/%0d",
                         i, count, empty, full, rd_valid, ram_dout, s_wp, s_rp, m_data, e_wp, e_rp);
            end
        end
    endtask

    task automatic test_random();
        logic w, r, c;
        for (int i = 0; i < 500; i++) begin
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 50);
            c = ($urandom_range(0, 99) < 5);
            cycle(w, r, c, 8'($urandom));
            checks++;
            if (dut_vec() !== exp_vec() || {s_wen, s_ren, s_wp, s_rp} !== {e_wen, e_ren, e_wp, e_rp} ||
                (m_rdv && ram_dout !== m_data)) begin
                errors++;
                $display("FAIL random_%0d: got %h en=%b%b wp=%0d rp=%0d d=%h want %h en=%b%b wp=%0d rp=%0d d=%h",
                         i, dut_vec(), s_wen, s_ren, s_wp, s_rp, ram_dout,
                         exp_vec(), e_wen, e_ren, e_wp, e_rp, m_data);
            end
        end
    endtask

    task automatic test_underflow_reset();
        cycle(1'b0, 1'b0, 1'b1, 8'd0);
        for (int i = 0; i < 300 && q.size() > 0; i++) cycle(1'b0, 1'b1, 1'b0, 8'd0);
        cycle(1'b0, 1'b1, 1'b0, 8'd0);
        checks++;
        if ({s_ren, count, empty, underflow} !== {1'b0, 9'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL underflow: got re=%b c=%0d e=%b unf=%b want 0/0/1/1", s_ren, count, empty, underflow);
        end
        cycle(1'b1, 1'b1, 1'b0, 8'h3C);
        checks++;
        if ({s_wen, s_ren, count, empty, underflow} !== {1'b1, 1'b0, 9'd1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL empty_rdwr: got we=%b re=%b c=%0d e=%b unf=%b want 1/0/1/0/1",
                     s_wen, s_ren, count, empty, underflow);
        end
        for (int i = 0; i < 49; i++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
        checks++;
        if (count !== 9'd50) begin
            errors++;
            $display("FAIL fill_50: got %0d want 50", count);
        end
        @(negedge clk);
        wr_req = 1'b1; rd_req = 1'b1;
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (dut_vec() !== 16'b000000000_0101000 || {s_wen, s_ren, s_wp, s_rp} !== 18'd0) begin
            errors++;
            $display("FAIL reset_mid: got %h en=%b%b wp=%0d rp=%0d want %h en=00 wp=0 rp=0",
                     dut_vec(), s_wen, s_ren, s_wp, s_rp, 16'b000000000_0101000);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_fill();
        test_full_rdwr();
        test_soak();
        test_random();
        test_underflow_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
